// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the dmem_arbiter and the data memory.
// slave = arbiter side, master = requester/memory environment side.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [2:0]        size0;
    logic [2:0]        size1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic              err;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              mem_read;
    logic              mem_write;
    logic [2:0]        mem_choose;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, size0, size1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output ack0, ack1, err, rdata, busy, mem_read, mem_write, mem_choose, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1, size0, size1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  ack0, ack1, err, rdata, busy, mem_read, mem_write, mem_choose, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer for the shared single-port data memory.
// One access at a time: IDLE -> ACCESS -> DONE; illegal commands go straight to DONE.
module dmem_arbiter #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave bus_io
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ACCESS = 2'b01,
        S_DONE   = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic              rr_q, rr_d;
    logic              port_q, port_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [2:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              err_o_q, err_o_d;
    logic              busy_q, busy_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;

    logic              any_req_s;
    logic              sel_s;
    logic              sel_we_s;
    logic [2:0]        sel_size_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              legal_s;

    // Unsigned sub-word codes only make sense for loads; 011/110/111 are undefined.
    function automatic logic cmd_legal(input logic we, input logic [2:0] size);
        logic ok;
        case (size)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            3'b100, 3'b101:         ok = ~we;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Winner selection and legality of the winning command.
    always_comb begin
        any_req_s = bus_io.req0 | bus_io.req1;
        if (bus_io.req0 && bus_io.req1) begin
            sel_s = (FIXED_PRIO != 0) ? 1'b0 : rr_q;
        end else begin
            sel_s = bus_io.req1;
        end
        sel_we_s    = sel_s ? bus_io.we1    : bus_io.we0;
        sel_size_s  = sel_s ? bus_io.size1  : bus_io.size0;
        sel_addr_s  = sel_s ? bus_io.addr1  : bus_io.addr0;
        sel_wdata_s = sel_s ? bus_io.wdata1 : bus_io.wdata0;
        legal_s     = cmd_legal(sel_we_s, sel_size_s);
    end

    // Next-state and next-output logic; outputs are computed one cycle ahead and registered.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        port_d  = port_q;
        we_d    = we_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        err_o_d = 1'b0;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_req_s) begin
                    port_d  = sel_s;
                    we_d    = sel_we_s;
                    size_d  = sel_size_s;
                    addr_d  = sel_addr_s;
                    wdata_d = sel_wdata_s;
                    if (legal_s) begin
                        err_d   = 1'b0;
                        state_d = S_ACCESS;
                        rd_d    = ~sel_we_s;
                        wr_d    = sel_we_s;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                        ack0_d  = ~sel_s;
                        ack1_d  = sel_s;
                        err_o_d = 1'b1;
                        rdata_d = {DATA_W{1'b0}};
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                state_d = S_DONE;
                ack0_d  = ~port_q;
                ack1_d  = port_q;
                err_o_d = err_q;
                rdata_d = we_q ? {DATA_W{1'b0}} : bus_io.mem_rdata;
            end
            S_DONE: begin
                state_d = S_IDLE;
                rr_d    = ~port_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset drops the memory strobes immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rr_q    <= 1'b0;
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 3'b000;
            addr_q  <= {ADDR_W{1'b0}};
            wdata_q <= {DATA_W{1'b0}};
            rdata_q <= {DATA_W{1'b0}};
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err_o_q <= 1'b0;
            busy_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            port_q  <= port_d;
            we_q    <= we_d;
            err_q   <= err_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            err_o_q <= err_o_d;
            busy_q  <= busy_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    assign bus_io.ack0       = ack0_q;
    assign bus_io.ack1       = ack1_q;
    assign bus_io.err        = err_o_q;
    assign bus_io.rdata      = rdata_q;
    assign bus_io.busy       = busy_q;
    assign bus_io.mem_read   = rd_q;
    assign bus_io.mem_write  = wr_q;
    assign bus_io.mem_choose = size_q;
    assign bus_io.mem_addr   = addr_q;
    assign bus_io.mem_wdata  = wdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic
// against a transaction-level model of arbitration order, latency and memory contents.
module tb_dmem_arbiter;
    typedef struct packed {
        logic        we;
        logic [2:0]  size;
        logic [5:0]  addr;
        logic [31:0] wdata;
    } op_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(6), .DATA_W(32)) if0 ();
    dmem_arbiter_if #(.ADDR_W(6), .DATA_W(32)) if1 ();

    dmem_arbiter #(.ADDR_W(6), .DATA_W(32), .FIXED_PRIO(0)) dut_rr (
        .clk(clk), .rst_n(rst_n), .bus_io(if0)
    );
    dmem_arbiter #(.ADDR_W(6), .DATA_W(32), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst_n(rst_n), .bus_io(if1)
    );

    // Environment memory behind the round-robin instance (big-endian, combinational read).
    logic [7:0]  mem0 [0:63];
    bit          mem_loaded = 1'b0;
    logic [5:0]  ea;
    logic [31:0] ew;
    always_comb begin
        ea = if0.mem_addr;
        ew = {mem0[ea], mem0[ea + 6'd1], mem0[ea + 6'd2], mem0[ea + 6'd3]};
        case (if0.mem_choose)
            3'b000:  if0.mem_rdata = {{24{ew[31]}}, ew[31:24]};
            3'b100:  if0.mem_rdata = {24'd0, ew[31:24]};
            3'b001:  if0.mem_rdata = {{16{ew[31]}}, ew[31:16]};
            3'b101:  if0.mem_rdata = {16'd0, ew[31:16]};
            3'b010:  if0.mem_rdata = ew;
            default: if0.mem_rdata = 32'd0;
        endcase
    end

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 64; i++) mem0[i] <= 8'h00;
            mem0[3]    <= 8'h11;
            mem0[7]    <= 8'h09;
            mem_loaded <= 1'b1;
        end else if (if0.mem_write) begin
            case (if0.mem_choose)
                3'b000, 3'b100: mem0[if0.mem_addr] <= if0.mem_wdata[7:0];
                3'b001, 3'b101: begin
                    mem0[if0.mem_addr]        <= if0.mem_wdata[15:8];
                    mem0[if0.mem_addr + 6'd1] <= if0.mem_wdata[7:0];
                end
                3'b010: begin
                    mem0[if0.mem_addr]        <= if0.mem_wdata[31:24];
                    mem0[if0.mem_addr + 6'd1] <= if0.mem_wdata[23:16];
                    mem0[if0.mem_addr + 6'd2] <= if0.mem_wdata[15:8];
                    mem0[if0.mem_addr + 6'd3] <= if0.mem_wdata[7:0];
                end
                default: ;
            endcase
        end
    end

    assign if1.mem_rdata = {8'hA5, 18'd0, if1.mem_addr};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model state: byte memory, pending requests, arbitration pointer.
    logic [7:0] ref_mem [0:63];
    op_t  q0[$], q1[$];
    op_t  cur [2];
    bit   pend [2];
    bit   m_busy;
    int   m_port, m_rr, m_grant, m_ack_cyc, free_cyc, cyc;
    op_t  m_op;
    int   log_port[$], log_cyc[$];
    logic [31:0] last_rd;
    logic        last_err;
    int          last_port;

    function automatic bit legal(input logic we, input logic [2:0] s);
        return !(s == 3'd3 || s == 3'd6 || s == 3'd7 || (we && (s == 3'd4 || s == 3'd5)));
    endfunction

    function automatic logic [31:0] ref_load(input logic [5:0] a, input logic [2:0] s);
        logic [7:0] b0, b1;
        int v;
        b0 = ref_mem[a];
        b1 = ref_mem[a + 6'd1];
        case (s)
            3'd0: begin v = int'(b0); if (v > 127) v = v - 256; return 32'(v); end
            3'd4: return 32'(b0);
            3'd1: begin v = int'(b0) * 256 + int'(b1); if (v > 32767) v = v - 65536; return 32'(v); end
            3'd5: return 32'(int'(b0) * 256 + int'(b1));
            3'd2: return {b0, b1, ref_mem[a + 6'd2], ref_mem[a + 6'd3]};
            default: return 32'd0;
        endcase
    endfunction

    function automatic void ref_store(input logic [5:0] a, input logic [2:0] s, input logic [31:0] d);
        int nb;
        nb = (s == 3'd2) ? 4 : ((s == 3'd1) ? 2 : 1);
        for (int i = 0; i < nb; i++) ref_mem[a + 6'(i)] = d[8*(nb-1-i) +: 8];
    endfunction

    function automatic op_t mk(input logic we, input logic [2:0] s, input logic [5:0] a, input logic [31:0] d);
        op_t o;
        o.we = we; o.size = s; o.addr = a; o.wdata = d;
        return o;
    endfunction

    task automatic drive(input int p, input logic v, input op_t o);
        if (p == 0) begin
            if0.req0 = v; if0.we0 = o.we; if0.size0 = o.size; if0.addr0 = o.addr; if0.wdata0 = o.wdata;
        end else begin
            if0.req1 = v; if0.we1 = o.we; if0.size1 = o.size; if0.addr1 = o.addr; if0.wdata1 = o.wdata;
        end
    endtask

    // Serve queued ops on the round-robin instance, predicting every cycle's outputs.
    task automatic run_engine(input bit gaps, input int budget);
        int n;
        int w;
        logic [31:0] exp_data;
        n = 0;
        free_cyc = cyc;
        while ((q0.size() != 0 || q1.size() != 0 || pend[0] || pend[1] || m_busy) && n < budget) begin
            @(negedge clk);
            n++;
            cyc++;
            chk("ack0", if0.ack0, m_busy && cyc == m_ack_cyc && m_port == 0);
            chk("ack1", if0.ack1, m_busy && cyc == m_ack_cyc && m_port == 1);
            chk("mem_read", if0.mem_read,
                m_busy && cyc == m_ack_cyc - 1 && legal(m_op.we, m_op.size) && !m_op.we);
            chk("mem_write", if0.mem_write,
                m_busy && cyc == m_ack_cyc - 1 && legal(m_op.we, m_op.size) && m_op.we);
            chk("busy", if0.busy, m_busy && cyc > m_grant && cyc <= m_ack_cyc);
            if (m_busy && cyc == m_ack_cyc) begin
                if (!legal(m_op.we, m_op.size) || m_op.we) exp_data = 32'd0;
                else exp_data = ref_load(m_op.addr, m_op.size);
                chk("err", if0.err, !legal(m_op.we, m_op.size));
                chk("rdata", if0.rdata, exp_data);
                last_rd = if0.rdata; last_err = if0.err; last_port = m_port;
                log_port.push_back(m_port);
                log_cyc.push_back(cyc);
                if (legal(m_op.we, m_op.size) && m_op.we) ref_store(m_op.addr, m_op.size, m_op.wdata);
                pend[m_port] = 1'b0;
                drive(m_port, 1'b0, m_op);
                m_busy   = 1'b0;
                free_cyc = cyc + 1;
                m_rr     = 1 - m_port;
            end
            if (!pend[0] && q0.size() != 0 && (!gaps || $urandom_range(0, 2) == 0)) begin
                cur[0] = q0.pop_front(); pend[0] = 1'b1; drive(0, 1'b1, cur[0]);
            end
            if (!pend[1] && q1.size() != 0 && (!gaps || $urandom_range(0, 2) == 0)) begin
                cur[1] = q1.pop_front(); pend[1] = 1'b1; drive(1, 1'b1, cur[1]);
            end
            if (!m_busy && cyc >= free_cyc && (pend[0] || pend[1])) begin
                if (pend[0] && pend[1]) w = m_rr;
                else w = pend[1] ? 1 : 0;
                m_busy    = 1'b1;
                m_port    = w;
                m_op      = cur[w];
                m_grant   = cyc;
                m_ack_cyc = cyc + (legal(m_op.we, m_op.size) ? 2 : 1);
            end
        end
        chk("engine_pending", q0.size() + q1.size() + int'(pend[0]) + int'(pend[1]) + int'(m_busy), 32'd0);
    endtask

    int   n0, n1, k;
    int   ord[$];

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
        ref_mem[3] = 8'h11;
        ref_mem[7] = 8'h09;
        pend[0] = 1'b0; pend[1] = 1'b0; m_busy = 1'b0; m_rr = 0; cyc = 0;
        m_port = 0; m_grant = 0; m_ack_cyc = 0; free_cyc = 0; m_op = mk(1'b0, 3'd2, 6'd0, 32'd0);
        drive(0, 1'b0, m_op);
        drive(1, 1'b0, m_op);
        if1.req0 = 1'b0; if1.req1 = 1'b0; if1.we0 = 1'b0; if1.we1 = 1'b0;
        if1.size0 = 3'b010; if1.size1 = 3'b010; if1.addr0 = 6'd1; if1.addr1 = 6'd2;
        if1.wdata0 = 32'd0; if1.wdata1 = 32'd0;
        rst_n = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ctrl", {if0.ack0, if0.ack1, if0.err, if0.busy, if0.mem_read, if0.mem_write}, 32'd0);
        chk("rst_rdata", if0.rdata, 32'd0);
        chk("rst_mem_cmd", {if0.mem_choose, if0.mem_addr}, 32'd0);
        chk("rst_mem_wdata", if0.mem_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", if0.busy, 1'b0);

        // Word load of preloaded 17
        q0.push_back(mk(1'b0, 3'b010, 6'd0, 32'd0));
        run_engine(1'b0, 20);
        chk("ld_word_17", last_rd, 32'h0000_0011);

        // Store DEADBEEF via port 1, then signed and unsigned byte loads
        q1.push_back(mk(1'b1, 3'b010, 6'd8, 32'hDEAD_BEEF));
        run_engine(1'b0, 20);
        chk("st_port", last_port, 32'd1);
        q0.push_back(mk(1'b0, 3'b000, 6'd8, 32'd0));
        run_engine(1'b0, 20);
        chk("ld_sbyte", last_rd, 32'hFFFF_FFDE);
        q0.push_back(mk(1'b0, 3'b100, 6'd8, 32'd0));
        run_engine(1'b0, 20);
        chk("ld_ubyte", last_rd, 32'h0000_00DE);

        // Illegal unsigned-half store: error ack, memory untouched
        q0.push_back(mk(1'b1, 3'b101, 6'd12, 32'hCAFE_F00D));
        run_engine(1'b0, 20);
        chk("illegal_err", last_err, 1'b1);
        q0.push_back(mk(1'b0, 3'b010, 6'd12, 32'd0));
        run_engine(1'b0, 20);
        chk("illegal_nowrite", last_rd, 32'd0);

        // Request dropped after grant still completes
        @(negedge clk);
        drive(0, 1'b1, mk(1'b0, 3'b010, 6'd0, 32'd0));
        @(negedge clk);
        chk("drop_busy", if0.busy, 1'b1);
        chk("drop_read", if0.mem_read, 1'b1);
        if0.req0 = 1'b0;
        @(negedge clk);
        chk("drop_ack0", if0.ack0, 1'b1);
        chk("drop_rdata", if0.rdata, 32'h0000_0011);
        @(negedge clk);
        chk("drop_idle", {if0.busy, if0.ack0}, 32'd0);
        m_rr = 1;

        // Both ports saturated: strict alternation, 3 cycles apart
        log_port.delete(); log_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(1'b0, 3'b010, 6'(4 * i), 32'd0));
            q1.push_back(mk(1'b0, 3'b001, 6'(4 * i + 2), 32'd0));
        end
        run_engine(1'b0, 60);
        chk("alt_count", log_port.size(), 32'd8);
        for (int i = 1; i < log_port.size(); i++) begin
            chk("alt_port", log_port[i], 1 - log_port[i-1]);
            chk("alt_gap", log_cyc[i] - log_cyc[i-1], 32'd3);
        end

        // Random traffic on both ports (addresses kept clear of 0..15)
        for (int i = 0; i < 20; i++) begin
            q0.push_back(mk(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 6'($urandom_range(16, 63)), $urandom));
            q1.push_back(mk(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 6'($urandom_range(16, 63)), $urandom));
        end
        run_engine(1'b1, 2000);

        // Reset during the ACCESS cycle of a store
        @(negedge clk);
        drive(0, 1'b1, mk(1'b1, 3'b010, 6'd4, 32'h1234_5678));
        @(negedge clk);
        chk("rst_acc_write", if0.mem_write, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_acc_ctrl", {if0.ack0, if0.ack1, if0.err, if0.busy, if0.mem_read, if0.mem_write}, 32'd0);
        chk("rst_acc_rdata", if0.rdata, 32'd0);
        chk("rst_acc_cmd", {if0.mem_choose, if0.mem_addr}, 32'd0);
        chk("rst_acc_wdata", if0.mem_wdata, 32'd0);
        if0.req0 = 1'b0;
        @(negedge clk);
        chk("rst_acc_noack", {if0.ack0, if0.ack1}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_acc_noack2", {if0.ack0, if0.ack1, if0.busy}, 32'd0);
        m_rr = 0;
        q0.push_back(mk(1'b0, 3'b010, 6'd4, 32'd0));
        run_engine(1'b0, 20);
        chk("rst_no_commit", last_rd, 32'h0000_0009);

        // Fixed priority: port 0 drains before port 1
        @(negedge clk);
        if1.req0 = 1'b1; if1.req1 = 1'b1;
        n0 = 0; n1 = 0; k = 0;
        while ((n0 < 4 || n1 < 4) && k < 80) begin
            @(negedge clk);
            k++;
            if (if1.ack0) begin
                ord.push_back(0);
                chk("fp_rdata0", if1.rdata, 32'hA500_0001);
                n0++;
                if (n0 == 4) if1.req0 = 1'b0;
            end
            if (if1.ack1) begin
                ord.push_back(1);
                chk("fp_rdata1", if1.rdata, 32'hA500_0002);
                n1++;
                if (n1 == 4) if1.req1 = 1'b0;
            end
        end
        chk("fp_count", ord.size(), 32'd8);
        for (int i = 0; i < ord.size(); i++) chk("fp_order", ord[i], (i < 4) ? 32'd0 : 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the shared single-port, byte-addressed data memory. Port 0 is the pipeline MEM stage. Port 1 is the debug/loader port. The block picks one request at a time, latches its command, drives the memory for exactly one access cycle, and returns registered read data with a one-cycle acknowledge. Big-endian byte order and the 3-bit size/sign code (`choose`) pass through unchanged to the memory.

## Interface
Parameters:
- `ADDR_W`, 6: byte address width.
- `DATA_W`, 32: data width.
- `FIXED_PRIO`, 0: 0 = round-robin; 1 = port 0 always wins.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0` / `req1` in 1: request; held high until the matching ack.
- `we0` / `we1` in 1: 1 = store, 0 = load.
- `size0` / `size1` in 3: choose code. 000 = byte signed, 001 = half signed, 010 = word, 100 = byte unsigned, 101 = half unsigned.
- `addr0` / `addr1` in ADDR_W: byte address.
- `wdata0` / `wdata1` in DATA_W: store data, LSB-aligned.
- `ack0` / `ack1` out 1: one-cycle completion pulse.
- `err` out 1: valid with ack; command was illegal.
- `rdata` out DATA_W: load result; valid with ack.
- `busy` out 1: high in ACCESS and DONE; pipeline stall source.
- `mem_read`, `mem_write` out 1: memory strobes.
- `mem_choose` out 3, `mem_addr` out ADDR_W, `mem_wdata` out DATA_W: memory command.
- `mem_rdata` in DATA_W: combinational read data from memory.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE**
  - No request: stay in IDLE.
  - Otherwise select the winner:
    - Only one of `req0`/`req1` high: that port wins.
    - Both high and `FIXED_PRIO`=1: port 0 wins.
    - Both high and `FIXED_PRIO`=0: the port named by pointer `rr` wins.
  - Latch winner id, we, size, addr, wdata.
  - Legality check on the latched command:
    - Illegal: size ∈ {011, 110, 111}, or a store with size ∈ {100, 101}.
    - Illegal command: set `err_q`, go to DONE, issue no memory strobe.
    - Legal command: go to ACCESS.
- **ACCESS** (exactly 1 cycle)
  - Drive `mem_addr`/`mem_choose`/`mem_wdata` from the latched registers.
  - `mem_write` = we, `mem_read` = !we.
  - Load: capture `mem_rdata` into `rdata` at the closing edge.
  - Store: the memory writes at the same edge, and `rdata` is set to 0.
  - Go to DONE.
- **DONE**
  - Pulse `ack` of the latched port; `err` = `err_q`.
  - Round-robin update: `rr` ← the other port after every grant, including error grants.
  - Go to IDLE.
- Memory strobes are 0 in IDLE and DONE. `mem_addr`/`mem_choose`/`mem_wdata` hold their latched values in all states (no X).
- Requester protocol:
  - Keep `req` and the command stable until ack.
  - Deasserting `req` early does not cancel the access: the latched command still executes and ack still pulses.
- Address arithmetic is left to memory. `addr` up to 2^ADDR_W-1 is passed as-is, and no alignment check is made.

## Timing
- Reset (async assert, sync release): state = IDLE, `rr` = 0, and all of the following are 0:
  - `ack0`, `ack1`, `err`, `busy`
  - `rdata`
  - `mem_read`, `mem_write`
  - `mem_addr`, `mem_choose`, `mem_wdata`
- Legal access:
  - Request sampled high in IDLE at cycle N.
  - ACCESS in N+1.
  - Ack and `rdata` valid in N+2.
  - Next grant evaluated in N+3.
  - Throughput is one access per 3 cycles.
- Illegal command: ack with `err`=1 in N+1. No memory strobe at any point.
- Both ports requesting continuously under round-robin: grants alternate, with acks 3 cycles apart.
- A request from the non-selected port waits while the FSM is busy. It is never dropped.
- `busy` = (state ≠ IDLE), registered.
- Reset asserted during ACCESS:
  - Strobes drop immediately, so the store is not committed if reset precedes the edge.
  - No ack is issued and `rdata` clears.

## Test plan
- Reset, then `req0` load word at addr 0 (memory holds 17) → `mem_read` high 1 cycle; `ack0`=1, `rdata`=0x00000011, `err`=0 two cycles after the request.
- `req1` store word 0xDEADBEEF at addr 8, then `req0` load signed byte at addr 8 → `ack1`; then `rdata`=0xFFFFFFDE. Unsigned byte load at addr 8 → 0x000000DE.
- `req0` and `req1` held together, 4 loads each, `FIXED_PRIO`=0 → acks strictly alternate 0,1,0,1,… spaced 3 cycles. With `FIXED_PRIO`=1, all port 0 requests complete first.
- `req0` store with size 101 → `ack0`=1, `err`=1 one cycle after the request; `mem_write` never rises; memory contents unchanged.
- `rst_n` pulsed low during ACCESS of a store 0x12345678 to addr 4 (memory holds 9) → no ack; all outputs 0; a subsequent load of addr 4 returns 0x00000009.
- `req0` dropped one cycle after the grant → access still completes and `ack0` still pulses; FSM returns to IDLE.
